// File: rtl/midi_note_decoder_pkg.sv
// MIDI protocol constants, decoder state encoding and message-length helper
// shared by the note decoder and its bench.
package midi_defs;

  localparam logic [3:0] NOTE_OFF    = 4'h8;
  localparam logic [3:0] NOTE_ON     = 4'h9;
  localparam logic [3:0] POLY_PRESS  = 4'hA;
  localparam logic [3:0] CC          = 4'hB;
  localparam logic [3:0] PROG_CHANGE = 4'hC;
  localparam logic [3:0] CH_PRESSURE = 4'hD;
  localparam logic [3:0] PITCH_BEND  = 4'hE;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] RT_FIRST    = 8'hF8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_D1 = 2'd1,
    S_WAIT_D2 = 2'd2,
    S_SYSEX   = 2'd3
  } state_t;

  function automatic logic [1:0] data_len(input logic [3:0] status_hi);
    return (status_hi == PROG_CHANGE || status_hi == CH_PRESSURE) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_note_decoder_if.sv
// Byte-stream input and note-event output bundle of the MIDI note decoder.
interface midi_note_decoder_if;
  logic       byte_rdy;
  logic [7:0] byte_in;
  logic [3:0] ch;
  logic       note_on;
  logic       note_off;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       all_off;

  modport master (output byte_rdy, byte_in, ch,
                  input  note_on, note_off, note, velocity, all_off);
  modport slave  (input  byte_rdy, byte_in, ch,
                  output note_on, note_off, note, velocity, all_off);
endinterface

// File: rtl/midi_note_decoder.sv
// Turns a MIDI byte stream into single-cycle note-on/note-off/all-off events,
// with running status, channel filtering, realtime pass-over and SysEx skipping.
module midi_note_decoder
  import midi_defs::*;
#(
  parameter bit OMNI      = 1'b0,
  parameter bit ALLOFF_CC = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  midi_note_decoder_if.slave  bus
);

  state_t     state;
  logic [3:0] status_hi;
  logic       match;
  logic [6:0] d1;
  logic       note_on_r;
  logic       note_off_r;
  logic       all_off_r;
  logic [6:0] note_r;
  logic [6:0] vel_r;

  logic [6:0] data_b;
  assign data_b = bus.byte_in[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      status_hi  <= 4'h0;
      match      <= 1'b0;
      d1         <= 7'd0;
      note_on_r  <= 1'b0;
      note_off_r <= 1'b0;
      all_off_r  <= 1'b0;
      note_r     <= 7'd0;
      vel_r      <= 7'd0;
    end else begin
      note_on_r  <= 1'b0;
      note_off_r <= 1'b0;
      all_off_r  <= 1'b0;
      if (bus.byte_rdy) begin
        if (!bus.byte_in[7]) begin
          case (state)
            S_WAIT_D1: begin
              d1 <= data_b;
              // One-byte messages never emit; stay here so running status repeats them.
              if (data_len(status_hi) == 2'd2)
                state <= S_WAIT_D2;
            end
            S_WAIT_D2: begin
              state <= S_WAIT_D1;
              if (match) begin
                case (status_hi)
                  NOTE_ON: begin
                    note_on_r  <= (data_b != 7'd0);
                    note_off_r <= (data_b == 7'd0);
                    note_r     <= d1;
                    vel_r      <= data_b;
                  end
                  NOTE_OFF: begin
                    note_off_r <= 1'b1;
                    note_r     <= d1;
                    vel_r      <= data_b;
                  end
                  CC: begin
                    all_off_r <= ALLOFF_CC &&
                                 (d1 == CC_ALL_SOUND_OFF || d1 == CC_ALL_NOTES_OFF);
                  end
                  default: ;
                endcase
              end
            end
            default: ;
          endcase
        end else if (bus.byte_in < RT_FIRST) begin
          // Realtime bytes (F8..FF) fall through untouched, even mid-message.
          if (bus.byte_in == SYSEX_START) begin
            status_hi <= 4'h0;
            state     <= S_SYSEX;
          end else if (bus.byte_in > SYSEX_START) begin
            status_hi <= 4'h0;
            state     <= S_IDLE;
          end else begin
            status_hi <= bus.byte_in[7:4];
            match     <= OMNI || (bus.byte_in[3:0] == bus.ch);
            state     <= S_WAIT_D1;
          end
        end
      end
    end
  end

  assign bus.note_on  = note_on_r;
  assign bus.note_off = note_off_r;
  assign bus.all_off  = all_off_r;
  assign bus.note     = note_r;
  assign bus.velocity = vel_r;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Bench for midi_note_decoder: directed scenarios plus random byte streams,
// checked against a message-level reference model for OMNI=0 and OMNI=1 instances.
module tb_midi_note_decoder;
  import midi_defs::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  midi_note_decoder_if bus0 ();
  midi_note_decoder_if bus1 ();

  midi_note_decoder #(.OMNI(1'b0), .ALLOFF_CC(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  midi_note_decoder #(.OMNI(1'b1), .ALLOFF_CC(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: message-level view (running status byte + collected data bytes).
  logic [7:0] m_rs    [2];
  bit         m_match [2];
  int         m_cnt   [2];
  int         m_d     [2][2];
  bit         e_on [2], e_off [2], e_all [2];
  int         e_note [2], e_vel [2];
  logic [3:0] cur_ch;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rs[i] = 8'h00; m_match[i] = 0; m_cnt[i] = 0;
      e_on[i] = 0; e_off[i] = 0; e_all[i] = 0; e_note[i] = 0; e_vel[i] = 0;
    end
  endtask

  task automatic model_idle();
    for (int i = 0; i < 2; i++) begin
      e_on[i] = 0; e_off[i] = 0; e_all[i] = 0;
    end
  endtask

  task automatic model_byte(input int i, input logic [7:0] b, input bit omni);
    int need;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_rs[i] = 8'h00; m_cnt[i] = 0;
    end else if (b >= 8'h80) begin
      m_rs[i] = b; m_cnt[i] = 0;
      m_match[i] = omni || (int'(b % 16) == int'(cur_ch));
    end else if (m_rs[i] != 8'h00) begin
      m_d[i][m_cnt[i]] = int'(b);
      m_cnt[i]++;
      need = (m_rs[i] / 16 == 8'hC || m_rs[i] / 16 == 8'hD) ? 1 : 2;
      if (m_cnt[i] == need) begin
        m_cnt[i] = 0;
        if (m_match[i] && need == 2) begin
          if (m_rs[i] / 16 == 8'h9) begin
            if (m_d[i][1] > 0) e_on[i] = 1; else e_off[i] = 1;
            e_note[i] = m_d[i][0]; e_vel[i] = m_d[i][1];
          end else if (m_rs[i] / 16 == 8'h8) begin
            e_off[i] = 1; e_note[i] = m_d[i][0]; e_vel[i] = m_d[i][1];
          end else if (m_rs[i] / 16 == 8'hB && (m_d[i][0] == 120 || m_d[i][0] == 123)) begin
            e_all[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_pulse0"}, {bus0.note_on, bus0.note_off, bus0.all_off}, {e_on[0], e_off[0], e_all[0]});
    chk({tag, "_note0"},  bus0.note,     e_note[0]);
    chk({tag, "_vel0"},   bus0.velocity, e_vel[0]);
    chk({tag, "_pulse1"}, {bus1.note_on, bus1.note_off, bus1.all_off}, {e_on[1], e_off[1], e_all[1]});
    chk({tag, "_note1"},  bus1.note,     e_note[1]);
    chk({tag, "_vel1"},   bus1.velocity, e_vel[1]);
  endtask

  task automatic set_ch(input logic [3:0] c);
    cur_ch = c; bus0.ch = c; bus1.ch = c;
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    @(posedge clk); #1;
    bus0.byte_rdy = 1'b1; bus0.byte_in = b;
    bus1.byte_rdy = 1'b1; bus1.byte_in = b;
    model_idle();
    model_byte(0, b, 1'b0);
    model_byte(1, b, 1'b1);
    @(posedge clk); #1;
    bus0.byte_rdy = 1'b0; bus1.byte_rdy = 1'b0;
    bus0.byte_in = $urandom_range(0, 255); bus1.byte_in = bus0.byte_in;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    @(posedge clk); #1;
    model_idle();
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    #3;
    rst_n = 1'b1;
  endtask

  logic [7:0] rb;
  int sel;

  initial begin
    bus0.byte_rdy = 1'b0; bus0.byte_in = 8'h00;
    bus1.byte_rdy = 1'b0; bus1.byte_in = 8'h00;
    set_ch(4'd0);
    model_reset();
    #12;
    compare_all("por");
    rst_n = 1'b1;

    // 1: basic note-on
    send(8'h90, "t1"); send(8'h3C, "t1"); send(8'h64, "t1");
    chk("t1_on",   bus0.note_on, 1);
    chk("t1_note", bus0.note, 60);
    chk("t1_vel",  bus0.velocity, 100);
    idle("t1_after");
    chk("t1_hold", bus0.note, 60);

    // 2: running status, note-on vel 0 becomes note-off
    send(8'h90, "t2"); send(8'h3C, "t2"); send(8'h64, "t2");
    send(8'h40, "t2"); send(8'h50, "t2");
    chk("t2_note64", bus0.note, 64);
    send(8'h3C, "t2"); send(8'h00, "t2");
    chk("t2_off", bus0.note_off, 1);
    chk("t2_vel0", bus0.velocity, 0);

    // 3: realtime byte inside a message
    send(8'h90, "t3"); send(8'h3C, "t3"); send(8'hF8, "t3"); send(8'h64, "t3");
    chk("t3_on", bus0.note_on, 1);

    // 4: channel filter vs OMNI
    set_ch(4'd1);
    send(8'h90, "t4"); send(8'h3C, "t4"); send(8'h64, "t4");
    chk("t4_filt0", bus0.note_on, 0);
    chk("t4_omni1", bus1.note_on, 1);
    send(8'h91, "t4"); send(8'h3C, "t4"); send(8'h64, "t4");
    chk("t4_match0", bus0.note_on, 1);
    set_ch(4'd0);

    // 5: SysEx skip, note-off, all-notes-off
    send(8'hF0, "t5"); send(8'h3C, "t5"); send(8'h64, "t5");
    send(8'hF7, "t5"); send(8'h3C, "t5"); send(8'h64, "t5");
    send(8'h80, "t5"); send(8'h3C, "t5"); send(8'h40, "t5");
    chk("t5_off_vel", bus0.velocity, 64);
    send(8'hB0, "t5"); send(8'h7B, "t5"); send(8'h00, "t5");
    chk("t5_alloff", bus0.all_off, 1);
    send(8'h78, "t5"); send(8'h00, "t5");
    chk("t5_alloff_rs", bus0.all_off, 1);

    // 6: reset mid-message
    send(8'h90, "t6"); send(8'h3C, "t6");
    do_reset();
    send(8'h64, "t6");
    chk("t6_nopulse", bus0.note_on, 0);
    send(8'h90, "t6"); send(8'h3C, "t6"); send(8'h64, "t6");
    chk("t6_on", bus0.note_on, 1);

    // Random byte streams
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) set_ch(4'($urandom_range(0, 1)));
      sel = $urandom_range(0, 99);
      if (sel < 50)      rb = 8'($urandom_range(0, 127));
      else if (sel < 56) rb = 8'h00;
      else if (sel < 60) rb = ($urandom_range(0, 1) != 0) ? 8'd120 : 8'd123;
      else if (sel < 85) rb = 8'(($urandom_range(8, 14) << 4) | $urandom_range(0, 1));
      else if (sel < 91) rb = 8'($urandom_range(8'hF8, 8'hFF));
      else if (sel < 95) rb = 8'hF0;
      else               rb = 8'($urandom_range(8'hF1, 8'hF7));
      send(rb, "rnd");
      if ($urandom_range(0, 3) == 0) idle("rnd_gap");
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
